// File: rtl/fcb_load_sequencer_if.sv
// Bus bundle between the load sequencer (master) and its memory read port and FCB register slave.
// Memory: req held until single-cycle ack. FCB: one-cycle cyc/stb strobes, read data combinational.
interface fcb_load_sequencer_if #(
    parameter int AW = 16
) ();
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          fcb_cyc;
    logic          fcb_stb;
    logic          fcb_we;
    logic [2:0]    fcb_adr;
    logic [31:0]   fcb_dat_o;
    logic [3:0]    fcb_sel;
    logic [31:0]   fcb_dat_i;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output fcb_cyc, fcb_stb, fcb_we, fcb_adr, fcb_dat_o, fcb_sel,
        input  fcb_dat_i
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  fcb_cyc, fcb_stb, fcb_we, fcb_adr, fcb_dat_o, fcb_sel,
        output fcb_dat_i
    );
endinterface

// File: rtl/fcb_load_sequencer.sv
// Streams a bitstream from word memory into the FCB registers, polling status between words.
// Latency: 3 config writes, then per word fetch + write + SETTLE_CYCLES + polls; every wait bounded by TIMEOUT_CYCLES.
// Backpressure: stalls in FETCH until mem_ack and in POLL until FCB status; FCB_SEQ_VERIFY_EN adds checksum readback.
module fcb_load_sequencer #(
    parameter int AW             = 16,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] bs_base_addr,
    input  logic [31:0]   bs_len_bits,
    input  logic [31:0]   bs_checksum,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [15:0]   words_sent,
    fcb_load_sequencer_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CFG_LEN = 4'd1;
    localparam logic [3:0] S_CFG_CHK = 4'd2;
    localparam logic [3:0] S_CFG_CTL = 4'd3;
    localparam logic [3:0] S_FETCH   = 4'd4;
    localparam logic [3:0] S_WRITE   = 4'd5;
    localparam logic [3:0] S_SETTLE  = 4'd6;
    localparam logic [3:0] S_POLL    = 4'd7;
    localparam logic [3:0] S_FINISH  = 4'd8;
    localparam logic [3:0] S_ERR     = 4'd9;
    localparam logic [3:0] S_SHUT    = 4'd10;
`ifdef FCB_SEQ_VERIFY_EN
    localparam logic [3:0] S_VERIFY  = 4'd11;
    localparam logic [3:0] S_VSTART  = 4'd12;
    localparam logic [3:0] S_VPOLL   = 4'd13;
`endif

    logic [3:0]    r_state;
    logic [TW-1:0] r_tmo;
    logic [AW-1:0] r_base;
    logic [31:0]   r_len;
    logic [31:0]   r_chk;
    logic [31:0]   r_nw;
    logic [31:0]   r_data;
    logic [15:0]   r_words_sent;
    logic          r_error;
    logic [1:0]    r_err_code;

    logic [3:0]    w_nxt;
    logic          w_err_set;
    logic [1:0]    w_err_val;
    logic          w_tmo_hit;
    logic          w_more;
    logic          w_shutting;
    logic [31:0]   w_nw;
    logic          w_wr;
    logic          w_rd;
    logic [2:0]    w_adr;
    logic [31:0]   w_dat;
    logic          w_unused_status;

    assign w_tmo_hit  = (r_tmo == TMO_LAST);
    assign w_more     = ({16'd0, r_words_sent} < r_nw);
    assign w_nw       = 32'((33'(bs_len_bits) + 33'd31) >> 5);
    assign w_shutting = (r_state == S_FINISH) || (r_state == S_ERR) || (r_state == S_SHUT);
    assign w_unused_status = ^bus.fcb_dat_i[31:2];

    always_comb begin
        w_nxt     = r_state;
        w_err_set = 1'b0;
        w_err_val = 2'd0;
        case (r_state)
            S_IDLE:    if (start) w_nxt = S_CFG_LEN;
            S_CFG_LEN: w_nxt = S_CFG_CHK;
            S_CFG_CHK: w_nxt = S_CFG_CTL;
            S_CFG_CTL: w_nxt = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ack) begin
                    w_nxt = S_WRITE;
                end else if (w_tmo_hit) begin
                    w_nxt     = S_ERR;
                    w_err_set = 1'b1;
                    w_err_val = 2'd1;
                end
            end
            S_WRITE:   w_nxt = S_SETTLE;
            S_SETTLE:  if (r_tmo == SETTLE_LAST) w_nxt = S_POLL;
            S_POLL: begin
                if (bus.fcb_dat_i[1]) begin
`ifdef FCB_SEQ_VERIFY_EN
                    w_nxt = S_VERIFY;
`else
                    w_nxt = S_FINISH;
`endif
                end else if (bus.fcb_dat_i[0] && w_more) begin
                    w_nxt = S_FETCH;
                end else if (w_tmo_hit) begin
                    w_nxt     = S_ERR;
                    w_err_set = 1'b1;
                    w_err_val = 2'd2;
                end
            end
`ifdef FCB_SEQ_VERIFY_EN
            S_VERIFY:  w_nxt = S_VSTART;
            S_VSTART:  w_nxt = S_VPOLL;
            S_VPOLL: begin
                if (bus.fcb_dat_i[2]) begin
                    w_nxt = S_FINISH;
                end else if (bus.fcb_dat_i[3]) begin
                    w_nxt     = S_ERR;
                    w_err_set = 1'b1;
                    w_err_val = 2'd3;
                end else if (w_tmo_hit) begin
                    w_nxt     = S_ERR;
                    w_err_set = 1'b1;
                    w_err_val = 2'd2;
                end
            end
`endif
            S_FINISH, S_ERR, S_SHUT: w_nxt = S_IDLE;
            default:   w_nxt = S_IDLE;
        endcase
        // Abort leaves error state untouched; states already writing control 0 just finish.
        if (abort && (r_state != S_IDLE) && !w_shutting) begin
            w_nxt     = S_SHUT;
            w_err_set = 1'b0;
        end
    end

    always_comb begin
        w_wr  = 1'b0;
        w_rd  = 1'b0;
        w_adr = 3'd0;
        w_dat = 32'd0;
        case (r_state)
            S_CFG_LEN: begin w_wr = 1'b1; w_adr = 3'd2; w_dat = r_len; end
            S_CFG_CHK: begin w_wr = 1'b1; w_adr = 3'd3; w_dat = r_chk; end
            S_CFG_CTL: begin w_wr = 1'b1; w_adr = 3'd0; w_dat = 32'd1; end
            S_WRITE:   begin w_wr = 1'b1; w_adr = 3'd1; w_dat = r_data; end
            S_POLL:    begin w_rd = 1'b1; w_adr = 3'd4; end
            S_FINISH, S_ERR, S_SHUT: begin w_wr = 1'b1; w_adr = 3'd0; end
`ifdef FCB_SEQ_VERIFY_EN
            S_VERIFY:  begin w_wr = 1'b1; w_adr = 3'd0; end
            S_VSTART:  begin w_wr = 1'b1; w_adr = 3'd0; w_dat = 32'd2; end
            S_VPOLL:   begin w_rd = 1'b1; w_adr = 3'd4; end
`endif
            default: ;
        endcase
    end

    assign bus.fcb_cyc   = w_wr | w_rd;
    assign bus.fcb_stb   = w_wr | w_rd;
    assign bus.fcb_we    = w_wr;
    assign bus.fcb_adr   = w_adr;
    assign bus.fcb_dat_o = w_dat;
    assign bus.fcb_sel   = {4{w_wr | w_rd}};
    assign bus.mem_req   = (r_state == S_FETCH);
    assign bus.mem_addr  = r_base + AW'(r_words_sent);

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FINISH);
    assign error      = r_error;
    assign err_code   = r_err_code;
    assign words_sent = r_words_sent;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_tmo        <= '0;
            r_base       <= '0;
            r_len        <= '0;
            r_chk        <= '0;
            r_nw         <= '0;
            r_data       <= '0;
            r_words_sent <= '0;
            r_error      <= 1'b0;
            r_err_code   <= 2'd0;
        end else begin
            r_state <= w_nxt;
            // Counter restarts on every state entry; it times both SETTLE and the timeouts.
            r_tmo   <= ((w_nxt != r_state) || (r_state == S_IDLE)) ? '0 : r_tmo + 1'b1;
            if ((r_state == S_IDLE) && start) begin
                r_base       <= bs_base_addr;
                r_len        <= bs_len_bits;
                r_chk        <= bs_checksum;
                r_nw         <= w_nw;
                r_words_sent <= '0;
                r_error      <= 1'b0;
                r_err_code   <= 2'd0;
            end
            if ((r_state == S_FETCH) && bus.mem_ack)
                r_data <= bus.mem_rdata;
            if ((r_state == S_WRITE) && (r_words_sent != 16'hFFFF))
                r_words_sent <= r_words_sent + 16'd1;
            if (w_err_set)
                r_err_code <= w_err_val;
            if (r_state == S_ERR)
                r_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fcb_load_sequencer.sv
// Randomized bench: memory + FCB slave models, expected bus transcripts derived from the load rules.
module tb_fcb_load_sequencer;
    localparam int AW  = 16;
    localparam int TMO = 4096;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] bs_base_addr = '0;
    logic [31:0]   bs_len_bits  = '0;
    logic [31:0]   bs_checksum  = '0;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic [15:0]   words_sent;

    fcb_load_sequencer_if #(.AW(AW)) bus ();

    fcb_load_sequencer #(.AW(AW), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .bs_base_addr(bs_base_addr), .bs_len_bits(bs_len_bits), .bs_checksum(bs_checksum),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .words_sent(words_sent), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus configuration (written by the main sequence only).
    logic [31:0] mem_arr [0:255];
    int ack_mode  = 0;
    int stat_mode = 0;
    int word_dly  = 5;
    int vmode     = 0;
    int vdly      = 7;

    // Slave model state and logs (written by the model only).
    int          mem_wait = 0;
    int          word_tmr = 0;
    int          vtmr     = 0;
    int          s_words  = 0;
    logic [31:0] s_len    = '0;
    logic [31:0] status   = '0;
    int          wr_adr_q [$];
    logic [31:0] wr_dat_q [$];
    logic [AW-1:0] addr_q [$];
    int done_cnt = 0, rd_cnt = 0, req_cyc = 0, bus_bad = 0, bad_rd = 0;

    assign bus.fcb_dat_i = (bus.fcb_cyc && bus.fcb_stb && !bus.fcb_we && bus.fcb_adr == 3'd4) ? status : 32'h0;

    always @(negedge clk) begin
        if (!reset) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            status = '0; word_tmr = 0; vtmr = 0; s_words = 0; mem_wait = 0;
        end else begin
            if (word_tmr > 0) begin
                word_tmr--;
                if (word_tmr == 0) begin
                    status[0] = 1'b1;
                    if (longint'(s_words) >= (longint'(s_len) + 31) / 32) status[1] = 1'b1;
                end
            end
            if (vtmr > 0) begin
                vtmr--;
                if (vtmr == 0) status[(vmode != 0) ? 3 : 2] = 1'b1;
            end
            if (bus.mem_req) req_cyc++;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (bus.mem_req && ack_mode == 0) begin
                if (mem_wait == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_arr[bus.mem_addr[7:0]];
                    addr_q.push_back(bus.mem_addr);
                    mem_wait = $urandom_range(0, 3);
                end else begin
                    mem_wait--;
                end
            end
            if (bus.fcb_stb) begin
                if (bus.fcb_sel != 4'hF || !bus.fcb_cyc) bus_bad++;
                if (bus.fcb_we) begin
                    wr_adr_q.push_back(int'(bus.fcb_adr));
                    wr_dat_q.push_back(bus.fcb_dat_o);
                    case (bus.fcb_adr)
                        3'd2: s_len = bus.fcb_dat_o;
                        3'd1: begin
                            s_words++;
                            status[0] = 1'b0;
                            if (stat_mode == 0) word_tmr = word_dly;
                        end
                        3'd0: begin
                            if (bus.fcb_dat_o == 32'd1) begin
                                status = '0; s_words = 0; word_tmr = 0; vtmr = 0;
                            end else if (bus.fcb_dat_o == 32'd2) begin
                                vtmr = vdly;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    rd_cnt++;
                    if (bus.fcb_adr != 3'd4) bad_rd++;
                end
            end else if (bus.fcb_cyc || bus.fcb_we) begin
                bus_bad++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // code: 0 success, 1 memory timeout, 2 poll timeout, 3 checksum mismatch
    task automatic run_job(input string nm, input logic [AW-1:0] b, input logic [31:0] l, input int code);
        int w0, a0, d0, r0, q0, nwr, cyc;
        longint nw;
        logic [31:0] ck;
        logic [AW-1:0] ea;
        int e_adr [$];
        logic [31:0] e_dat [$];
        w0 = wr_adr_q.size(); a0 = addr_q.size(); d0 = done_cnt; r0 = rd_cnt; q0 = req_cyc;
        ck = $urandom;
        bs_base_addr = b; bs_len_bits = l; bs_checksum = ck;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        chk({nm, "/idle"}, busy, 1'b0);

        nw  = (longint'(l) + 31) / 32;
        nwr = (code == 1) ? 0 : (code == 2) ? 1 : int'(nw);
        e_adr.push_back(2); e_dat.push_back(l);
        e_adr.push_back(3); e_dat.push_back(ck);
        e_adr.push_back(0); e_dat.push_back(32'd1);
        for (int i = 0; i < nwr; i++) begin
            ea = b + AW'(i);
            e_adr.push_back(1); e_dat.push_back(mem_arr[ea[7:0]]);
        end
`ifdef FCB_SEQ_VERIFY_EN
        if (code == 0 || code == 3) begin
            e_adr.push_back(0); e_dat.push_back(32'd0);
            e_adr.push_back(0); e_dat.push_back(32'd2);
        end
`endif
        e_adr.push_back(0); e_dat.push_back(32'd0);

        chk({nm, "/nwrites"}, wr_adr_q.size() - w0, e_adr.size());
        for (int i = 0; i < e_adr.size(); i++) begin
            if (w0 + i < wr_adr_q.size()) begin
                chk($sformatf("%s/wr%0d_adr", nm, i), wr_adr_q[w0 + i], e_adr[i]);
                chk($sformatf("%s/wr%0d_dat", nm, i), wr_dat_q[w0 + i], e_dat[i]);
            end
        end
        chk({nm, "/nfetch"}, addr_q.size() - a0, nwr);
        for (int i = 0; i < nwr; i++) begin
            if (a0 + i < addr_q.size())
                chk($sformatf("%s/maddr%0d", nm, i), 32'(addr_q[a0 + i]), 32'(b + AW'(i)));
        end
        chk({nm, "/done"}, done_cnt - d0, (code == 0) ? 1 : 0);
        chk({nm, "/error"}, error, (code != 0) ? 1 : 0);
        chk({nm, "/err_code"}, err_code, code);
        chk({nm, "/words_sent"}, words_sent, nwr);
        if (code == 1) chk({nm, "/fetch_cycles"}, req_cyc - q0, TMO);
        if (code == 2) chk({nm, "/poll_reads"}, rd_cnt - r0, TMO);
        chk({nm, "/bus_bad"}, bus_bad, 0);
        chk({nm, "/bad_rd_adr"}, bad_rd, 0);
    endtask

    task automatic wait_writes(input string nm, input int target);
        int cyc = 0;
        while (wr_adr_q.size() < target && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk({nm, "/reached"}, (wr_adr_q.size() >= target) ? 1 : 0, 1);
    endtask

    initial begin
        int w0, d0, n, wsz, vcode;
        for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;

        #2 reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_words_sent", words_sent, 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_strobes", {bus.fcb_cyc, bus.fcb_stb, bus.fcb_we}, 0);
        chk("rst_dat_o", bus.fcb_dat_o, 0);
        reset = 1'b1;
        @(negedge clk);

        mem_arr[8'h10] = 32'hA5A5A5A5;
        mem_arr[8'h11] = 32'h0F0F0F0F;
        word_dly = 40;
        run_job("len64", 16'h0010, 32'd64, 0);
        word_dly = 3;
        run_job("len33", 16'h0080, 32'd33, 0);
        run_job("len32", 16'h0005, 32'd32, 0);
        for (int k = 0; k < 6; k++) begin
            word_dly = $urandom_range(1, 20);
            run_job($sformatf("rnd%0d", k), AW'($urandom_range(0, 200)), $urandom_range(1, 200), 0);
        end

`ifdef FCB_SEQ_VERIFY_EN
        vcode = 3;
`else
        vcode = 0;
`endif
        vmode = 1;
        run_job("vfail", 16'h001E, 32'd96, vcode);
        vmode = 0;
        run_job("vpass", 16'h0040, 32'd70, 0);

        ack_mode = 1;
        run_job("mem_tmo", 16'h0028, 32'd64, 1);
        ack_mode = 0;
        stat_mode = 1;
        run_job("poll_tmo", 16'h0032, 32'd64, 2);
        stat_mode = 0;

        // Abort in SETTLE of word 1, with a start pulse while busy.
        word_dly = 10;
        w0 = wr_adr_q.size(); d0 = done_cnt;
        bs_base_addr = 16'h0060; bs_len_bits = 32'd128; bs_checksum = $urandom;
        #1 start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_writes("abort_w1", w0 + 4);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk("abort_busy_pre", busy, 1);
        chk("abort_ws_kept", words_sent, 1);
        abort = 1'b1;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (busy && n < 50);
        abort = 1'b0;
        chk("abort_latency", n, 2);
        chk("abort_nwrites", wr_adr_q.size() - w0, 5);
        if (wr_adr_q.size() > 0) begin
            chk("abort_last_adr", wr_adr_q[wr_adr_q.size() - 1], 0);
            chk("abort_last_dat", wr_dat_q[wr_dat_q.size() - 1], 0);
        end
        chk("abort_done", done_cnt - d0, 0);
        chk("abort_error", error, 0);
        chk("abort_err_code", err_code, 0);
        chk("abort_words_sent", words_sent, 1);

        // Async reset mid-transfer: immediate idle, no control-0 write.
        w0 = wr_adr_q.size();
        bs_base_addr = 16'h0070; bs_len_bits = 32'd160;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_writes("rmid_w1", w0 + 4);
        repeat (3) begin @(negedge clk); #1; end
        reset = 1'b0;
        #1;
        chk("rmid_busy", busy, 0);
        chk("rmid_strobe", bus.fcb_stb, 0);
        chk("rmid_words_sent", words_sent, 0);
        wsz = wr_adr_q.size();
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rmid_no_write", wr_adr_q.size(), wsz);
        chk("rmid_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fcb_load_sequencer.md
Name: fcb_load_sequencer

Overview:
- Autonomous configuration sequencer: moves a bitstream from a 32-bit word memory into the FCB register interface, then optionally triggers readback and checks the Adler checksum result.
- Sits between the SoC (start/config inputs) and the FCB Wishbone-style slave port, acting as the FCB's only bus master.
- Sets the length, checksum and control registers, then streams the data words and polls status.
- Frees the CPU from per-word polling.

Parameters:
- AW, 16, memory word-address width.
- SETTLE_CYCLES, 2, idle cycles after each FCB write before the first status poll (must be >= 1).
- TIMEOUT_CYCLES, 4096, maximum cycles spent in any wait or poll state before an error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active low
- start  in  1  one-cycle pulse; accepted only in IDLE
- abort  in  1  level; forces shutdown from any non-IDLE state
- bs_base_addr  in  AW  first memory word address
- bs_len_bits  in  32  bitstream length in bits (>0)
- bs_checksum  in  32  expected Adler-32 value
- busy  out  1  high from start accept until return to IDLE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky; cleared by next accepted start
- err_code  out  2  0 none, 1 memory timeout, 2 FCB poll timeout, 3 checksum mismatch
- words_sent  out  16  count of words written to the FCB bitstream register
- mem_req  out  1  read request, held until mem_ack
- mem_addr  out  AW  read address
- mem_ack  in  1  read data valid, single cycle
- mem_rdata  in  32  read data
- fcb_cyc, fcb_stb, fcb_we  out  1 each  bus strobes
- fcb_adr  out  3  0 control, 1 bitstream write, 2 length, 3 checksum, 4 status
- fcb_dat_o  out  32  write data
- fcb_sel  out  4  byte selects; always 4'hF when strobing
- fcb_dat_i  in  32  read data; combinational from slave

Behaviour:
- Reset (async, active low): state IDLE; all outputs 0; words_sent 0; mem_addr 0; internal counters 0.
- FCB write: cyc=stb=we=1 for exactly one cycle. FCB read: cyc=stb=1, we=0 for one cycle, with fcb_dat_i sampled at that edge. Strobes are low in all other cycles.
- Word count: NW = ceil(bs_len_bits/32), computed as (len+31)>>5 and latched at start.
- States:
  - IDLE: on start, latch inputs, clear error/err_code/words_sent, set busy, go to CFG_LEN.
  - CFG_LEN: write addr2 = len; go to CFG_CHK.
  - CFG_CHK: write addr3 = checksum; go to CFG_CTL.
  - CFG_CTL: write addr0 = 1; go to FETCH.
  - FETCH: assert mem_req with mem_addr = base + words_sent; on mem_ack, capture data and go to WRITE.
  - WRITE: write addr1 = data; increment words_sent; go to SETTLE.
  - SETTLE: wait SETTLE_CYCLES; go to POLL.
  - POLL: read addr4 every cycle.
    - If status[1] is set, go to VERIFY when compiled in, else FINISH.
    - Else if status[0] is set and words_sent < NW, go to FETCH.
    - Else keep polling.
  - FINISH: write addr0 = 0; pulse done; go to IDLE.
  - ERR: write addr0 = 0; set error; go to IDLE.
- Timeout counter resets on every state entry. Reaching TIMEOUT_CYCLES in FETCH gives err_code 1; in POLL or VPOLL it gives err_code 2; either way go to ERR.
- words_sent saturates at 16'hFFFF.
- abort in any non-IDLE state: next cycle goes to ERR-like shutdown, writing control 0 and returning to IDLE. No done pulse; error and err_code are unchanged.
- start while busy is ignored.
- Asynchronous reset mid-transfer returns to IDLE immediately; no control-0 write is issued.
- mem_ack outside FETCH is ignored.

Optional Feature:
- Macro FCB_SEQ_VERIFY_EN.
- Defined: adds three states.
  - VERIFY: write addr0 = 0.
  - VSTART: write addr0 = 2.
  - VPOLL: read addr4 until status[2] or status[3] is set.
- status[2] leads to FINISH. status[3] sets err_code 3 and goes to ERR.
- Undefined: these states and the err_code 3 path are absent; status[1] goes directly to FINISH.

Test Plan:
- len=64, memory holds {A5A5A5A5, 0F0F0F0F}, slave model asserts word_complt 40 cycles after each write and bitstream_complt after the 2nd word -> FCB write sequence is addr2=64, addr3, addr0=1, addr1=A5A5A5A5, addr1=0F0F0F0F, addr0=0; words_sent=2; one done pulse.
- len=33 -> NW=2; exactly two addr1 writes; mem_addr = base, then base+1.
- mem_ack never asserted -> after 4096 FETCH cycles, err_code=1, error=1, control-0 write issued, busy=0, no done.
- Status stuck at 0 after a write -> err_code=2 after TIMEOUT_CYCLES.
- With FCB_SEQ_VERIFY_EN, model returns status[3] -> writes addr0=0 then addr0=2, then err_code=3. Returning status[2] instead -> done pulse.
- abort asserted during SETTLE of word 1 -> control-0 write, IDLE next cycle, error=0. A start pulse while busy is ignored, and words_sent is not cleared.
